// File: rtl/gate_sweep_checker.sv
// Purpose: drives all four {a,b} vectors into a 2-input gate and checks y_in against the selected truth table.
// Latency: done pulses 4*SETTLE cycles after the start-accepting edge (1 cycle for an invalid op).
// Backpressure: none; start is honoured only in IDLE and ignored (not queued) while RUN or DONE.
module gate_sweep_checker #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Hold count at which the gate output has settled and is sampled.
    localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

    state_t     state;
    logic [2:0] op_lat;
    logic [1:0] vec;
    logic [3:0] cnt;

    logic       op_valid;
    logic       exp_y;
    logic       mismatch;
    logic [2:0] err_next;

    // Reference truth table for the latched gate type, evaluated on the driven stimulus.
    always_comb begin
        exp_y = 1'b0;
        case (op_lat)
            3'd0:    exp_y = a & b;
            3'd1:    exp_y = a | b;
            3'd2:    exp_y = a ^ b;
            3'd3:    exp_y = ~(a & b);
            3'd4:    exp_y = ~(a | b);
            3'd5:    exp_y = ~(a ^ b);
            default: exp_y = 1'b0;
        endcase
    end

    // Mismatch detection and saturating error count including the vector sampled this edge.
    always_comb begin
        op_valid = (op_lat < 3'd6);
        mismatch = (y_in != exp_y);
        err_next = err_count;
        if (mismatch && (err_count < 3'd4)) begin
            err_next = err_count + 3'd1;
        end
    end

    // Sweep controller: IDLE -> RUN (hold each vector SETTLE cycles, sample on the last) -> DONE -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_lat    <= 3'd0;
            vec       <= 2'd0;
            cnt       <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_vec  <= 4'd0;
            err_count <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_lat    <= op;
                        fail_vec  <= 4'd0;
                        err_count <= 3'd0;
                        vec       <= 2'd0;
                        cnt       <= 4'd0;
                        a         <= 1'b0;
                        b         <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!op_valid) begin
                        // Unknown gate type: report every vector as failing without sweeping.
                        fail_vec  <= 4'hF;
                        err_count <= 3'd4;
                        pass      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (cnt != LAST_CNT) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt       <= 4'd0;
                        err_count <= err_next;
                        if (mismatch) begin
                            fail_vec[vec] <= 1'b1;
                        end
                        if (vec == 2'd3) begin
                            a     <= 1'b0;
                            b     <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 3'd0);
                            state <= DONE;
                        end else begin
                            vec      <= vec + 2'd1;
                            {a, b}   <= vec + 2'd1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Purpose: checks gate_sweep_checker (SETTLE=2 and SETTLE=1) against a cycle-offset model plus directed literals.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [2:0] op;
    int         mode;   // 0 correct gate, 1 gate replaced by OR, 2 output stuck at 1

    logic       a0, b0, busy0, done0, pass0, y0;
    logic [3:0] fv0;
    logic [2:0] ec0;
    logic       a1, b1, busy1, done1, pass1, y1;
    logic [3:0] fv1;
    logic [2:0] ec1;

    int checks = 0;
    int errors = 0;

    function automatic logic ref_gate(input logic [2:0] o, input logic x, input logic z);
        case (o)
            3'd0:    return x & z;
            3'd1:    return x | z;
            3'd2:    return x ^ z;
            3'd3:    return ~(x & z);
            3'd4:    return ~(x | z);
            3'd5:    return ~(x ^ z);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic gate_model(input int m, input logic [2:0] o, input logic x, input logic z);
        if (m == 0) return ref_gate(o, x, z);
        if (m == 1) return x | z;
        return 1'b1;
    endfunction

    assign y0 = gate_model(mode, op, a0, b0);
    assign y1 = gate_model(mode, op, a1, b1);

    gate_sweep_checker #(.SETTLE(2)) u0 (
        .clk(clk), .rst(rst), .start(start), .op(op), .y_in(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_vec(fv0), .err_count(ec0)
    );

    gate_sweep_checker #(.SETTLE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .y_in(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .err_count(ec1)
    );

    // ---------------- behavioural model ----------------
    // mk = cycles since the accept edge (-1 when idle); outputs follow from mk by plain arithmetic.
    int         msettle[2] = '{2, 1};
    int         mk[2]      = '{-1, -1};
    logic [2:0] mop[2];
    logic [3:0] mfull[2];
    logic [3:0] mhold[2];
    logic       mpass[2];
    bit         model_live = 1'b0;

    function automatic logic [3:0] sweep_result(input logic [2:0] o);
        logic [3:0] r;
        logic [1:0] v;
        r = 4'd0;
        if (o >= 3'd6) return 4'hF;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            r[i] = (ref_gate(o, v[1], v[0]) != gate_model(mode, o, v[1], v[0]));
        end
        return r;
    endfunction

    function automatic int end_k(input int i);
        return (mop[i] >= 3'd6) ? 1 : 4 * msettle[i];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mk[i] = -1; mop[i] = 3'd0; mfull[i] = 4'd0; mhold[i] = 4'd0; mpass[i] = 1'b0;
            end else if (mk[i] < 0) begin
                if (start) begin
                    mk[i] = 0; mop[i] = op; mhold[i] = 4'd0; mfull[i] = sweep_result(op);
                end
            end else begin
                mk[i] = mk[i] + 1;
                if (mk[i] == end_k(i)) begin
                    mhold[i] = mfull[i];
                    mpass[i] = (mfull[i] == 4'd0);
                end else if (mk[i] > end_k(i)) begin
                    mk[i] = -1;
                end
            end
        end
        if (rst) model_live = 1'b1;
    end

    // Expected {a,b,busy,done,pass,fail_vec,err_count}
    function automatic logic [11:0] exp_vec(input int i);
        int         k, e;
        logic [1:0] ab;
        logic       bz, dn, ps;
        logic [3:0] fv;
        k = mk[i]; e = end_k(i);
        ab = 2'd0; bz = 1'b0; dn = 1'b0; ps = mpass[i]; fv = mhold[i];
        if (k >= 0 && k < e) begin
            bz = 1'b1;
            fv = 4'd0;
            if (mop[i] < 3'd6) begin
                ab = 2'(k / msettle[i]);
                for (int v = 0; v < 4; v++)
                    if ((v + 1) * msettle[i] <= k) fv[v] = mfull[i][v];
            end
        end else if (k == e) begin
            dn = 1'b1;
        end
        return {ab, bz, dn, ps, fv, 3'($countones(fv))};
    endfunction

    // Per-cycle comparison of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        logic [11:0] act[2];
        logic [11:0] want;
        act[0] = {a0, b0, busy0, done0, pass0, fv0, ec0};
        act[1] = {a1, b1, busy1, done1, pass1, fv1, ec1};
        if (model_live) begin
            for (int i = 0; i < 2; i++) begin
                want = exp_vec(i);
                checks = checks + 1;
                if (act[i] !== want) begin
                    errors = errors + 1;
                    $display("FAIL model_cmp inst%0d t=%0t got {a,b,busy,done,pass,fv,ec}=%b want %b",
                             i, $time, act[i], want);
                end
            end
        end
    end

    // ---------------- cycle bookkeeping ----------------
    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc[2] = '{-1, -1};
    int ndone[2]    = '{0, 0};

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (done_cyc[0] < 0) done_cyc[0] = cyc;
            ndone[0] = ndone[0] + 1;
        end
        if (done1 === 1'b1) begin
            if (done_cyc[1] < 0) done_cyc[1] = cyc;
            ndone[1] = ndone[1] + 1;
        end
    end

    task automatic chk(input string name, input int act, input int want);
        checks = checks + 1;
        if (act != want) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents start for exactly one edge (the accept edge); returns just after it.
    task automatic drive_start(input logic [2:0] o);
        done_cyc[0] = -1;
        done_cyc[1] = -1;
        op    = o;
        start = 1'b1;
        tick(1);
        acc_cyc = cyc;
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; mode = 0;
        tick(3);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_fv", int'(fv0), 0);
        chk("rst_ab", int'({a0, b0}), 0);
        rst = 1'b0;
        tick(2);

        // Correct AND gate: full pass, latency 4*SETTLE
        mode = 0;
        drive_start(3'd0);
        tick(1);
        chk("and_ab_hold_s2", int'({a0, b0}), 0);
        chk("and_ab_step_s1", int'({a1, b1}), 1);
        tick(11);
        chk("and_lat_s2", done_cyc[0] - acc_cyc, 8);
        chk("and_lat_s1", done_cyc[1] - acc_cyc, 4);
        chk("and_pass", int'(pass0), 1);
        chk("and_fv", int'(fv0), 0);
        chk("and_ec", int'(ec0), 0);

        // Reset on the 5th edge of a sweep: no done, outputs cleared, then clean rerun
        ndone[0] = 0;
        drive_start(3'd0);
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_pass_cleared", int'(pass0), 0);
        chk("abort_busy", int'(busy0), 0);
        tick(3);
        chk("abort_no_done", ndone[0], 0);
        drive_start(3'd0);
        tick(12);
        chk("rerun_lat", done_cyc[0] - acc_cyc, 8);
        chk("rerun_pass", int'(pass0), 1);

        // AND expected, gate behaves as OR
        mode = 1;
        drive_start(3'd0);
        tick(12);
        chk("or_fv_s2", int'(fv0), 4'b0110);
        chk("or_fv_s1", int'(fv1), 4'b0110);
        chk("or_ec", int'(ec0), 2);
        chk("or_pass", int'(pass0), 0);

        // NAND expected, output stuck at 1
        mode = 2;
        drive_start(3'd3);
        tick(12);
        chk("nand_fv", int'(fv0), 4'b1000);
        chk("nand_ec", int'(ec0), 1);
        chk("nand_pass", int'(pass0), 0);

        // Invalid op: immediate DONE with all vectors failing
        mode = 0;
        drive_start(3'd7);
        tick(12);
        chk("inv_lat_s2", done_cyc[0] - acc_cyc, 1);
        chk("inv_lat_s1", done_cyc[1] - acc_cyc, 1);
        chk("inv_fv", int'(fv0), 4'hF);
        chk("inv_ec", int'(ec0), 4);
        chk("inv_pass", int'(pass0), 0);

        // start pulses while busy and during DONE are ignored
        drive_start(3'd0);
        tick(2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("ign_busy_after_done", int'(busy0), 0);
        chk("ign_lat", done_cyc[0] - acc_cyc, 8);
        chk("ign_pass", int'(pass0), 1);
        tick(2);
        chk("ign_still_idle", int'(busy0), 0);
        tick(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001: Parameter SETTLE, default 2, legal range 1..15: number of clock cycles each input vector is held before the gate output is sampled.
REQ-002: clk  input  1  sole clock; all state changes on its rising edge.
REQ-003: rst  input  1  reset; synchronous and active-high.
REQ-004: start  input  1  request a new truth-table sweep; sampled only in IDLE.
REQ-005: op  input  3  gate under test: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 invalid.
REQ-006: y_in  input  1  output of the 2-input gate under test.
REQ-007: a, b  output  1 each  stimulus driven to the gate under test.
REQ-008: busy  output  1  high while a sweep is in progress.
REQ-009: done  output  1  one-cycle pulse when a sweep finishes.
REQ-010: pass  output  1  result of the last completed sweep.
REQ-011: fail_vec  output  4  per-vector mismatch flags; bit i is vector {a,b}=i.
REQ-012: err_count  output  3  number of mismatching vectors, 0..4.

Function
REQ-013: The FSM shall have exactly three states: IDLE, RUN and DONE.
REQ-014: In IDLE with start=1 at an edge, the block shall latch op, clear fail_vec and err_count, set vec=0 and cnt=0, enter RUN, and set busy=1.
REQ-015: In IDLE with start=0, the block shall hold all outputs unchanged.
REQ-016: In RUN and DONE, start shall be ignored with no queuing.
REQ-017: In RUN, {a,b} shall equal vec (a = MSB), changing only at the edge that advances vec.
REQ-018: In RUN, while cnt < SETTLE-1, each edge shall increment cnt.
REQ-019: In RUN, at the edge where cnt == SETTLE-1, the block shall compare y_in with expected(op_latched, a, b), set fail_vec[vec] and increment err_count on mismatch, and reset cnt to 0.
REQ-020: At the sampling edge of REQ-019, if vec < 3 the block shall increment vec; if vec == 3 it shall enter DONE.
REQ-021: Sampling shall use the y_in value present at the sampling edge; the same-edge update of fail_vec shall be visible from the next cycle.
REQ-022: On entry to DONE, the block shall set busy=0, done=1 and pass = (err_count_final == 0), and drive a=b=0.
REQ-023: DONE shall last exactly one cycle, then return to IDLE with done=0.
REQ-024: done shall go high exactly 4*SETTLE cycles after the start-accepting edge.
REQ-025: pass, fail_vec and err_count shall hold their values until the next accepted start or reset.
REQ-026: With op=6 or 7 at the start-accepting edge, the block shall skip RUN and enter DONE on the next edge with fail_vec=4'hF, err_count=4 and pass=0.
REQ-027: In IDLE and DONE, a=b=0.
REQ-028: cnt shall be 4 bits, vec 2 bits and err_count saturating at 4, with no wrap-around.

Reset
REQ-029: rst=1 at an edge shall force state=IDLE, a=b=0, busy=0, done=0, pass=0, fail_vec=0, err_count=0, vec=0, cnt=0 and latched op=0.
REQ-030: rst shall take priority over start and over any RUN or DONE activity, including mid-sweep; no done pulse shall be produced for an aborted sweep.
REQ-031: After rst deasserts, the first start shall begin a clean sweep.

Verification (SETTLE=2 unless stated)
REQ-032: Start with op=0 and a correct AND gate on y_in -> {a,b} steps 00,01,10,11 every 2 cycles; done pulses 8 cycles after the accept edge; pass=1, fail_vec=0000, err_count=0.
REQ-033: Start with op=0 and y_in tied to a|b -> fail_vec=0110, err_count=2, pass=0.
REQ-034: Start with op=3 (NAND) and y_in stuck at 1 -> fail_vec=1000, err_count=1, pass=0.
REQ-035: Start with op=7 -> done is high 1 cycle after the accept edge; fail_vec=1111, err_count=4, pass=0; a=b=0 throughout.
REQ-036: Assert rst at cycle 5 of a sweep -> all outputs return to reset values next cycle with no done pulse; a new start produces a full correct sweep.
REQ-037: Pulse start while busy=1 and during DONE -> no effect; rerun REQ-032 with SETTLE=1 -> done 4 cycles after the accept edge.
